// File: rtl/px_ss_ctrl_pkg.sv
// Shared types for the px_subsampler configuration controller:
// controller state encoding and the per-axis skip configuration record.
package px_ss_ctrl_pkg;

    localparam int RES_W = 16;

    typedef logic [RES_W-1:0] res_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GCD_X,
        ST_DIV_X_I,
        ST_DIV_X_K,
        ST_GCD_Y,
        ST_DIV_Y_I,
        ST_DIV_Y_K,
        ST_PEND
    } ctrl_state_t;

    typedef struct packed {
        res_t interval;
        res_t to_skip;
        res_t add;
    } axis_cfg_t;

endpackage

// File: rtl/px_ss_if.sv
// Skip-configuration bundle consumed by px_subsampler; the controller drives
// the master side, the subsampler latches the fields at start of frame.
interface px_ss_if #(
    parameter int RES_WIDTH = 16
);
    logic [RES_WIDTH-1:0] px_skip_interval;
    logic [RES_WIDTH-1:0] px_to_skip;
    logic [RES_WIDTH-1:0] add_px_skip_interval;
    logic [RES_WIDTH-1:0] ln_skip_interval;
    logic [RES_WIDTH-1:0] ln_to_skip;
    logic [RES_WIDTH-1:0] add_ln_skip_interval;

    modport master (
        output px_skip_interval, px_to_skip, add_px_skip_interval,
        output ln_skip_interval, ln_to_skip, add_ln_skip_interval
    );

    modport slave (
        input px_skip_interval, px_to_skip, add_px_skip_interval,
        input ln_skip_interval, ln_to_skip, add_ln_skip_interval
    );
endinterface

// File: rtl/px_ss_udiv.sv
// Restoring unsigned divider: one quotient bit per cycle, done_o pulses
// once the full quotient is available.
module px_ss_udiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    // The trial remainder needs one extra bit; when it fits, the true
    // difference is below 2^WIDTH so the truncated subtraction is exact.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_fits  = w_shift >= {1'b0, r_div};
    assign w_diff  = w_shift[WIDTH-1:0] - r_div;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start_i) begin
                r_rem  <= '0;
                r_quo  <= dividend_i;
                r_div  <= divisor_i;
                r_cnt  <= CW'(WIDTH);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_quo <= {r_quo[WIDTH-2:0], w_fits};
                r_rem <= w_fits ? w_diff : w_shift[WIDTH-1:0];
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient_o = r_quo;
    assign done_o     = r_done;

endmodule

// File: rtl/px_ss_ctrl.sv
// Configuration controller for px_subsampler: reduces src/dst ratios with a
// subtractive GCD and a shared divider, committing new settings only between frames.
module px_ss_ctrl
    import px_ss_ctrl_pkg::*;
#(
    parameter int RES_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [RES_WIDTH-1:0] src_res_x_i,
    input  logic [RES_WIDTH-1:0] src_res_y_i,
    input  logic [RES_WIDTH-1:0] dst_res_x_i,
    input  logic [RES_WIDTH-1:0] dst_res_y_i,
    input  logic                 mon_tvalid_i,
    input  logic                 mon_tready_i,
    input  logic                 mon_tlast_i,
    input  logic                 mon_tuser_i,
    px_ss_if.master              px_ss_o,
    output logic                 busy_o,
    output logic                 cfg_err_o,
    output logic                 applied_o
);
    ctrl_state_t          r_state;
    ctrl_state_t          w_state_next;
    logic [RES_WIDTH-1:0] r_src_x, r_src_y, r_dst_x, r_dst_y;
    logic [RES_WIDTH-1:0] r_a, r_b, r_interval;
    logic [RES_WIDTH-1:0] r_active_src_y, r_line_cnt;
    axis_cfg_t            r_shadow_x, r_shadow_y, r_cur_x, r_cur_y;
    logic                 r_in_frame, r_cfg_err, r_applied;
    logic                 w_accept, w_req_bad, w_hs, w_eof, w_commit;
    logic                 w_div_start, w_div_done;
    logic [RES_WIDTH-1:0] w_div_dividend, w_div_quotient, w_line_eff;

    assign w_accept  = cfg_valid_i && (r_state == ST_IDLE);
    assign w_req_bad = (src_res_x_i == '0) || (src_res_y_i == '0) ||
                       (dst_res_x_i == '0) || (dst_res_y_i == '0) ||
                       (dst_res_x_i > src_res_x_i) || (dst_res_y_i > src_res_y_i);

    // The SOF beat is line 0 even if a previous frame was truncated.
    assign w_hs       = mon_tvalid_i && mon_tready_i;
    assign w_line_eff = mon_tuser_i ? '0 : r_line_cnt;
    assign w_eof      = w_hs && mon_tlast_i && (r_active_src_y != '0) &&
                        (w_line_eff == r_active_src_y - RES_WIDTH'(1));
    assign w_commit   = (r_state == ST_PEND) && (w_eof || (!r_in_frame && !mon_tvalid_i));

    // After the GCD loop r_a holds g and stays put through both divisions.
    px_ss_udiv #(.WIDTH(RES_WIDTH)) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (w_div_start),
        .dividend_i (w_div_dividend),
        .divisor_i  (r_a),
        .quotient_o (w_div_quotient),
        .done_o     (w_div_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_div_start    = 1'b0;
        w_div_dividend = r_src_x;
        case (r_state)
            ST_IDLE:    if (w_accept && !w_req_bad) w_state_next = ST_GCD_X;
            ST_GCD_X:   if (r_b == '0) begin
                            w_div_start    = 1'b1;
                            w_div_dividend = r_src_x;
                            w_state_next   = ST_DIV_X_I;
                        end
            ST_DIV_X_I: if (w_div_done) begin
                            w_div_start    = 1'b1;
                            w_div_dividend = r_dst_x;
                            w_state_next   = ST_DIV_X_K;
                        end
            ST_DIV_X_K: if (w_div_done) w_state_next = ST_GCD_Y;
            ST_GCD_Y:   if (r_b == '0) begin
                            w_div_start    = 1'b1;
                            w_div_dividend = r_src_y;
                            w_state_next   = ST_DIV_Y_I;
                        end
            ST_DIV_Y_I: if (w_div_done) begin
                            w_div_start    = 1'b1;
                            w_div_dividend = r_dst_y;
                            w_state_next   = ST_DIV_Y_K;
                        end
            ST_DIV_Y_K: if (w_div_done) w_state_next = ST_PEND;
            ST_PEND:    if (w_commit) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {r_src_x, r_src_y, r_dst_x, r_dst_y} <= '0;
            {r_a, r_b, r_interval}               <= '0;
            {r_shadow_x, r_shadow_y}             <= '0;
            {r_cur_x, r_cur_y}                   <= '0;
            r_active_src_y <= '0;
            r_line_cnt     <= '0;
            r_in_frame     <= 1'b0;
            r_cfg_err      <= 1'b0;
            r_applied      <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && w_req_bad;
            r_applied <= w_commit;
            case (r_state)
                ST_IDLE: if (w_accept && !w_req_bad) begin
                    r_src_x <= src_res_x_i;
                    r_src_y <= src_res_y_i;
                    r_dst_x <= dst_res_x_i;
                    r_dst_y <= dst_res_y_i;
                    r_a     <= src_res_x_i;
                    r_b     <= dst_res_x_i;
                end
                ST_GCD_X, ST_GCD_Y: if (r_b != '0) begin
                    if (r_a >= r_b) begin
                        r_a <= r_a - r_b;
                    end else begin
                        r_a <= r_b;
                        r_b <= r_a;
                    end
                end
                ST_DIV_X_I, ST_DIV_Y_I: if (w_div_done) r_interval <= w_div_quotient;
                ST_DIV_X_K: if (w_div_done) begin
                    r_shadow_x <= '{interval: r_interval, to_skip: r_interval - w_div_quotient, add: '0};
                    r_a        <= r_src_y;
                    r_b        <= r_dst_y;
                end
                ST_DIV_Y_K: if (w_div_done)
                    r_shadow_y <= '{interval: r_interval, to_skip: r_interval - w_div_quotient, add: '0};
                default: ;
            endcase
            if (w_commit) begin
                r_cur_x        <= r_shadow_x;
                r_cur_y        <= r_shadow_y;
                r_active_src_y <= r_src_y;
            end
            if (w_eof) begin
                r_in_frame <= 1'b0;
                r_line_cnt <= '0;
            end else if (w_hs) begin
                r_in_frame <= 1'b1;
                r_line_cnt <= w_line_eff + RES_WIDTH'(mon_tlast_i);
            end
        end
    end

    assign cfg_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign cfg_err_o   = r_cfg_err;
    assign applied_o   = r_applied;

    assign px_ss_o.px_skip_interval     = r_cur_x.interval;
    assign px_ss_o.px_to_skip           = r_cur_x.to_skip;
    assign px_ss_o.add_px_skip_interval = r_cur_x.add;
    assign px_ss_o.ln_skip_interval     = r_cur_y.interval;
    assign px_ss_o.ln_to_skip           = r_cur_y.to_skip;
    assign px_ss_o.add_ln_skip_interval = r_cur_y.add;

endmodule

// File: doc/px_ss_ctrl.md
# px_ss_ctrl

Configuration controller for `px_subsampler`. It accepts a requested output resolution over a valid/ready config port and reduces each source/destination ratio to lowest terms with an iterative GCD and shared divider. It then drives the `px_ss_if` fields and commits them only at a frame boundary, by snooping the subsampler's input AXI4-Stream handshake, so a frame is never subsampled with mixed settings.

## Interface

- Clocking: one clock; reset is synchronous and active-high (`clk_i`, `rst_i`).

Parameters:
- `RES_WIDTH`, default 16: resolution and `px_ss_if` field width. It must match `px_ss_if`.

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: synchronous active-high reset.
- `cfg_valid_i` input 1: config request valid.
- `cfg_ready_o` output 1: high only in IDLE.
- `src_res_x_i`, `src_res_y_i` input RES_WIDTH each: source frame size.
- `dst_res_x_i`, `dst_res_y_i` input RES_WIDTH each: requested output size.
- `mon_tvalid_i`, `mon_tready_i`, `mon_tlast_i`, `mon_tuser_i` input 1 each: tap of the subsampler's `video_i`.
- `px_ss_o` `px_ss_if.master`: `px_skip_interval`, `px_to_skip`, `add_px_skip_interval`, `ln_skip_interval`, `ln_to_skip`, `add_ln_skip_interval`.
- `busy_o` output 1: computing or pending.
- `cfg_err_o` output 1: one-cycle pulse on a rejected request.
- `applied_o` output 1: one-cycle pulse on commit.

## Operation

- **Request acceptance and validation**
  - A request is accepted on `cfg_valid_i && cfg_ready_o`; all four sizes are captured.
  - A request is rejected if any size is 0, `dst_x > src_x`, or `dst_y > src_y`.
  - On rejection: `cfg_err_o` pulses the next cycle, the FSM stays in IDLE, and outputs are unchanged.
- **Per-axis computation (S = src, D = dst)**
  - `g = gcd(S, D)` by subtractive Euclid, one step per cycle: if `b == 0`, done; else if `a >= b`, `a -= b`; else swap.
  - `interval = S / g` and `keep = D / g`, via the shared divider.
  - `to_skip = interval - keep`; `add_*_skip_interval = 0`.
  - When `S == D`, this yields `to_skip = 0`, which is pass-through.
- **FSM**
  - IDLE → GCD_X → DIV_X_I → DIV_X_K → GCD_Y → DIV_Y_I → DIV_Y_K → PEND → IDLE.
  - PEND leaves on commit. Results sit in shadow registers until then.
- **Frame tracking**
  - `hs = mon_tvalid_i && mon_tready_i`.
  - `in_frame` is set on any `hs` and cleared on EOF.
  - `line_cnt` is cleared on `hs && mon_tuser_i` (the SOF beat then counts as line 0) and on EOF. It increments on `hs && mon_tlast_i`.
  - EOF = `hs && mon_tlast_i && line_cnt == active_src_y - 1`.
  - EOF detection is disabled while `active_src_y == 0` (i.e. after reset).
- **Commit**
  - Condition: PEND and (EOF, or (`!in_frame && !mon_tvalid_i`)).
  - Effect: shadow → `px_ss_o`, `active_src_y ← src_y`, `applied_o` pulses, FSM → IDLE.
  - A commit never occurs in the cycle before or during a non-EOF beat. The subsampler's SOF latch therefore always sees complete new values.
- **Reset**
  - Every `px_ss_o` field is 0 (pass-through).
  - `cfg_ready_o = 1`, `busy_o = 0`, pulses 0.
  - `active_src_y = 0`, `in_frame = 0`, `line_cnt = 0`.
  - Reset mid-computation or in PEND discards the request.

## Timing

- `cfg_ready_o` drops the cycle after acceptance.
- `busy_o` is high from the cycle after acceptance until the cycle after commit.
- Computation latency per axis: GCD steps (≤ S + D) + 2 × 18 cycles for the divider.
- Divider: 16 iterations plus start and done.
- `px_ss_o` changes exactly one cycle after the commit condition and is otherwise stable.
- `applied_o` is asserted in that same cycle.
- Width rules:
  - All arithmetic is unsigned RES_WIDTH.
  - `to_skip` cannot underflow, because `D ≤ S` is guaranteed.
  - The GCD terminates because `D ≠ 0`.

## Structure

- Package `px_ss_ctrl_pkg` holds:
  - The FSM state enum.
  - `RES_WIDTH`-based `res_t` typedef.
  - A struct for one axis result: interval, to_skip, add.
- Sub-module `px_ss_udiv`: RES_WIDTH restoring unsigned divider.
  - Ports: `start_i`, `dividend_i`, `divisor_i`, `quotient_o`, `done_o`.
  - Shared by all four divisions.

## Test plan

- 1920x1080 → 1280x720, stream idle:
  - `applied_o` pulses.
  - px interval 3 / skip 1; ln interval 3 / skip 1; add fields 0.
- 1920x1080 → 1000x1080:
  - px interval 48 / skip 23.
  - ln interval 1 / skip 0.
- Request `dst_x = 2000 > src_x = 1920`:
  - `cfg_err_o` pulses once.
  - `px_ss_o` unchanged and `cfg_ready_o` stays 1.
- Commit timing:
  - Setup: 1280x720 is active; a 960x540 request is issued during line 100 of a continuous stream.
  - Outputs do not change until the cycle after the tlast of line 719.
  - The next SOF beat sees px interval 4 / skip 1.
- Back-to-back frames with no idle gap:
  - Commit happens only on EOF.
  - `line_cnt` resets on each SOF.
  - No frame is split between configurations.
- `rst_i` asserted during GCD_X:
  - All fields return to 0 and `busy_o` = 0.
  - A new request is accepted on the next cycle and completes normally.
